// File: rtl/spi_rx_pack32.sv
// SPI receive packer: collects 1-4 received bytes into a 32-bit word
// and queues the words in a first-word-fall-through FIFO.
module spi_rx_pack32 #(
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  nbytes,
    input  logic        abort,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    output logic [31:0] out_data,
    output logic [2:0]  out_nbytes,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        fifo_full,
    output logic        busy,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        PUSH
    } state_t;

    state_t      state;
    logic [2:0]  target;
    logic [2:0]  cnt;
    logic [2:0]  cnt_inc;
    logic [31:0] acc;
    logic [31:0] acc_in;

    logic [31:0]   mem_data [FIFO_DEPTH];
    logic [2:0]    mem_nb   [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign out_valid  = (count != '0);
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign out_data   = out_valid ? mem_data[rptr] : '0;
    assign out_nbytes = out_valid ? mem_nb[rptr] : '0;
    assign busy       = (state != IDLE);

    assign pop  = out_valid & out_ready;
    assign push = (state == PUSH) & (~fifo_full | pop);

    assign cnt_inc = cnt + 3'd1;

    // Byte slot index is cnt[1:0]; cnt never exceeds 3 while still collecting.
    always_comb begin
        acc_in = acc;
        if (MSB_FIRST)
            acc_in = {acc[23:0], rx_byte};
        else
            acc_in[{cnt[1:0], 3'b000} +: 8] = rx_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            target   <= '0;
            cnt      <= '0;
            acc      <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        target <= (nbytes == 3'd0 || nbytes > 3'd4) ? 3'd4 : nbytes;
                        cnt    <= '0;
                        acc    <= '0;
                        state  <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (rx_dv) begin
                        acc <= acc_in;
                        cnt <= cnt_inc;
                    end
                    if (rx_dv && cnt_inc == target)
                        state <= PUSH;
                    else if (abort)
                        state <= (rx_dv || cnt != '0) ? PUSH : IDLE;
                end
                PUSH: begin
                    if (rx_dv)
                        overflow <= 1'b1;
                    if (push)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wptr] <= acc;
            mem_nb[wptr]   <= cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
